// File: rtl/alu_ctrl_pkg.sv
// Shared ALUOp encodings, ALU control codes and the occupancy-counter sizing helper.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_ctrl_pkg;

    // ALUOp values driven by the main control unit
    localparam logic [1:0] ALUOP_RTYPE = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_ADD   = 2'b10;

    // Native width of the ALU control code (largest code is 18)
    localparam int ALU_CODE_W = 5;
    typedef logic [ALU_CODE_W-1:0] alu_code_t;

    localparam alu_code_t ALU_ADD  = 5'd0;
    localparam alu_code_t ALU_SUB  = 5'd1;
    localparam alu_code_t ALU_MUL  = 5'd6;
    localparam alu_code_t ALU_DIV  = 5'd7;
    localparam alu_code_t ALU_RSVD = 5'd14;

    // Occupancy counter width: enough bits for the longest latency, never below one
    function automatic int occ_cnt_w(input int mul_lat, input int div_lat);
        int m;
        m = (mul_lat > div_lat) ? mul_lat : div_lat;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Maps {alu_op, opcode} to an ALU control code, an illegal flag and the occupancy reload value.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int OPC_W   = 6,
    parameter int CNT_W   = 7,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8,
    parameter int LAT_W   = 3
) (
    input  logic [1:0]       alu_op,
    input  logic [OPC_W-1:0] opcode,
    output logic [CNT_W-1:0] code,
    output logic             illegal,
    output logic [LAT_W-1:0] lat
);

    alu_code_t raw;

    // Function-field decode; code 14 is skipped so opcodes 16..19 land on 15..18
    always_comb begin
        raw     = ALU_ADD;
        illegal = 1'b0;
        lat     = '0;
        case (alu_op)
            ALUOP_ADD: raw = ALU_ADD;
            ALUOP_SUB: raw = ALU_SUB;
            ALUOP_RTYPE: begin
                if (opcode >= OPC_W'(2) && opcode <= OPC_W'(15)) begin
                    raw = alu_code_t'(opcode - OPC_W'(2));
                end else if (opcode >= OPC_W'(16) && opcode <= OPC_W'(19)) begin
                    raw = alu_code_t'(opcode - OPC_W'(1));
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
        // Reload value is occupancy minus the issue cycle itself; zero means single-cycle
        if (!illegal && raw == ALU_MUL) begin
            lat = LAT_W'(MUL_LAT - 1);
        end else if (!illegal && raw == ALU_DIV) begin
            lat = LAT_W'(DIV_LAT - 1);
        end
    end

    assign code = CNT_W'(raw);

endmodule

// File: rtl/alu_ctrl_issue.sv
// Registered ALU control issue stage: decodes requests and blocks issue while MUL/DIV occupy the ALU.
// Latency: 1 cycle from accept to out_valid; 1 request/cycle for single-cycle codes.
// Backpressure: in_ready drops while the ALU is occupied, the output is stalled, or flush is high.
module alu_ctrl_issue
    import alu_ctrl_pkg::*;
#(
    parameter int OPC_W   = 6,
    parameter int CNT_W   = 7,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [OPC_W-1:0] opcode,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] alu_cnt,
    output logic             illegal,
    output logic             busy
);

    localparam int LAT_W = occ_cnt_w(MUL_LAT, DIV_LAT);

    logic [LAT_W-1:0] cnt;
    logic [LAT_W-1:0] dec_lat;
    logic [CNT_W-1:0] dec_code;
    logic             dec_ill;
    logic             accept;

    alu_ctrl_decode #(
        .OPC_W   (OPC_W),
        .CNT_W   (CNT_W),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .LAT_W   (LAT_W)
    ) u_decode (
        .alu_op  (alu_op),
        .opcode  (opcode),
        .code    (dec_code),
        .illegal (dec_ill),
        .lat     (dec_lat)
    );

    // out_ready reaches in_ready combinationally so a draining slot can refill in the same cycle
    assign in_ready = (cnt == '0) && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign busy     = (cnt != '0);

    // Output register and occupancy counter; flush wins over accept, drain and countdown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            alu_cnt   <= '0;
            illegal   <= 1'b0;
            cnt       <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            illegal   <= 1'b0;
            cnt       <= '0;
        end else if (accept) begin
            // accept implies cnt==0, so no countdown competes with the reload
            out_valid <= 1'b1;
            alu_cnt   <= dec_code;
            illegal   <= dec_ill;
            cnt       <= dec_lat;
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (cnt != '0) begin
                cnt <= cnt - LAT_W'(1);
            end
        end
    end

endmodule

// File: doc/alu_ctrl_issue.md
Name: alu_ctrl_issue

Overview:
- Registered, parametrised ALU control decoder with valid/ready handshake between the decode stage and the ALU.
- Maps {alu_op, opcode} to an ALU control code and flags illegal encodings.
- Blocks new issue while a multi-cycle operation (MUL/DIV) occupies the ALU.
- Sits between the main control unit and the ALU datapath; supports pipeline flush.

Parameters:
- OPC_W, 6: opcode width.
- CNT_W, 7: ALU control code width.
- MUL_LAT, 3: ALU occupancy in cycles for MUL (code 6); must be >= 1.
- DIV_LAT, 8: ALU occupancy in cycles for DIV (code 7); must be >= 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- alu_op  in  2  ALUOp from the main control unit.
- opcode  in  OPC_W  instruction function field.
- flush  in  1  synchronous pipeline kill.
- out_valid  out  1  alu_cnt/illegal valid.
- out_ready  in  1  ALU accepts the output.
- alu_cnt  out  CNT_W  ALU control code, zero-extended.
- illegal  out  1  decoded request was an illegal encoding.
- busy  out  1  multi-cycle occupancy counter is nonzero.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, alu_cnt=0, illegal=0, occupancy counter=0. in_ready reads 1 once reset is released.
- in_ready is combinational: (cnt==0) && (!out_valid || out_ready) && !flush.
- Accept: in_valid && in_ready at a rising edge. The decoded result is registered, and out_valid=1 the next cycle (latency 1).
- Throughput: 1 request per cycle for single-cycle codes when out_ready is held high.
- Output hold: while out_valid && !out_ready, alu_cnt and illegal stay stable.
- Output clear: out_valid drops after a transfer unless a new request is accepted in the same cycle.
- Decode, alu_op=2'b10: code 0 (ADD), opcode ignored.
- Decode, alu_op=2'b01: code 1 (SUB), opcode ignored.
- Decode, alu_op=2'b00:
  - opcode 2..15 -> code = opcode-2 (0..13).
  - opcode 16..19 -> code = opcode-1 (15..18). Code 14 is reserved and never produced.
  - Any other opcode -> illegal.
- Decode, alu_op=2'b11: illegal.
- Illegal requests: out_valid=1, illegal=1, alu_cnt=0. The occupancy counter is not loaded.
- Multi-cycle occupancy:
  - Accepting code 6 loads cnt = MUL_LAT-1; accepting code 7 loads cnt = DIV_LAT-1.
  - cnt decrements each cycle while nonzero and saturates at 0.
  - busy = (cnt!=0).
  - With LAT=1 the counter is not loaded and the op behaves as single-cycle.
- Counter width: $clog2(max(MUL_LAT, DIV_LAT)) bits, minimum 1.
- Flush (sampled at the clock edge) has priority over everything except reset:
  - clears out_valid, illegal and cnt;
  - in_ready=0 during the flush cycle, so no request is accepted in that cycle;
  - alu_cnt keeps its value (don't-care while out_valid=0).
- Simultaneous transfer and accept in the same cycle: the new value replaces the old one, out_valid stays 1.
- Reset mid-occupancy: counter cleared immediately; in_ready=1 after release.
- No combinational path from in_valid to out_valid. The only combinational path from out_ready is to in_ready.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - ALUOp constants ALUOP_RTYPE=2'b00, ALUOP_SUB=2'b01, ALUOP_ADD=2'b10;
  - ALU code constants (ALU_ADD=0, ALU_SUB=1, ALU_MUL=6, ALU_DIV=7, ALU_RSVD=14);
  - a typedef for the code width.
- One natural sub-module: alu_ctrl_decode, purely combinational, mapping {alu_op, opcode} to {code, illegal, lat}.
- alu_ctrl_issue holds the registers, the occupancy counter and the handshake.

Test Plan:
- Reset then sweep:
  - alu_op=00, opcode 2..19 with out_ready=1 -> alu_cnt 0..13, then 15..18, one per cycle, out_valid 1 cycle after each accept;
  - opcode 0, 1 and 20 -> illegal=1, alu_cnt=0.
- alu_op=10/opcode=5 -> alu_cnt=0; alu_op=01/opcode=5 -> alu_cnt=1; alu_op=11 -> illegal=1.
- Accept opcode 9 (DIV), DIV_LAT=8, in_valid held high -> busy=1 and in_ready=0 for exactly 7 cycles after the accept; the next request is accepted on the 8th cycle.
- Backpressure: out_ready=0 for 4 cycles after an accept of opcode 4 -> alu_cnt=2 held, in_ready=0; on out_ready=1 a simultaneous new accept yields out_valid continuously high.
- Flush during MUL occupancy (cnt=1) with out_valid=1 -> next cycle out_valid=0, busy=0, in_ready=1.
- Assert rst_n=0 asynchronously mid-cycle during DIV occupancy -> out_valid, busy and illegal drop immediately without a clock edge; after release in_ready=1.
